sipo_db: RTL and testbench

Double-buffered, multi-lane serial-in/parallel-out frame buffer with valid/ready handshakes on both sides. It collects `depth_p` elements of `width_p` bits, taking `lanes_p` elements per accepted beat, and presents each completed frame as one wide word. A second bank lets filling continue while the downstream consumer holds the previous frame. It sits between the byte/word stream and the systolic array's wide operand loaders, replacing the single-bank `sipo`.

---
 rtl/sipo_db.sv | 108 ++++++++++
 tb/tb_sipo_db.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_db.sv
// Double-buffered multi-lane serial-in/parallel-out frame buffer with valid/ready on both sides.
// Optional partial-frame flush with zero fill is built only when SIPO_DB_FLUSH_EN is defined.
module sipo_db #(
    parameter int width_p = 8,
    parameter int depth_p = 128,
    parameter int lanes_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [width_p*lanes_p-1:0]   data_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [width_p*depth_p-1:0]   data_o
);

    localparam int beats_lp  = depth_p / lanes_p;
    localparam int ptr_w_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int beat_w_lp = width_p * lanes_p;
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(beats_lp - 1);

    logic [1:0][width_p*depth_p-1:0] bank_q, bank_d;
    logic                            fill_sel_q, fill_sel_d;
    logic                            out_sel_q, out_sel_d;
    logic [1:0]                      full_q, full_d;
    logic [ptr_w_lp-1:0]             ptr_q, ptr_d;
    logic                            in_acc, out_acc, close;

    // Reset gates ready so no beat is taken while the block is held in reset.
    assign ready_o = reset_ni & ~full_q[fill_sel_q];
    assign valid_o = full_q[out_sel_q];
    assign data_o  = bank_q[out_sel_q];
    assign in_acc  = valid_i & ready_o;
    assign out_acc = valid_o & ready_i;

`ifndef SIPO_DB_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush_i;
`endif

    always_comb begin
        bank_d     = bank_q;
        ptr_d      = ptr_q;
        fill_sel_d = fill_sel_q;
        out_sel_d  = out_sel_q;
        full_d     = full_q;
        close      = 1'b0;

        if (in_acc) begin
            for (int b = 0; b < beats_lp; b++) begin
                if (ptr_q == ptr_w_lp'(b)) begin
                    bank_d[fill_sel_q][b*beat_w_lp +: beat_w_lp] = data_i;
                end
            end
            if (ptr_q == last_lp) begin
                close = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end

`ifdef SIPO_DB_FLUSH_EN
        // ptr_d already includes a beat accepted this cycle, so zero from there up.
        if (flush_i && ready_o && !close && (in_acc || ptr_q != '0)) begin
            close = 1'b1;
            for (int b = 0; b < beats_lp; b++) begin
                if (ptr_w_lp'(b) >= ptr_d) begin
                    bank_d[fill_sel_q][b*beat_w_lp +: beat_w_lp] = '0;
                end
            end
        end
`endif

        if (close) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = ~fill_sel_q;
            ptr_d              = '0;
        end

        // Fill and out banks always differ when the fill bank is writable.
        if (out_acc) begin
            full_d[out_sel_q] = 1'b0;
            out_sel_d         = ~out_sel_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q      <= '0;
            fill_sel_q <= 1'b0;
            out_sel_q  <= 1'b0;
            full_q     <= 2'b00;
        end else begin
            ptr_q      <= ptr_d;
            fill_sel_q <= fill_sel_d;
            out_sel_q  <= out_sel_d;
            full_q     <= full_d;
        end
    end

    // Bank storage is deliberately not reset; stale contents are harmless once full_q is cleared.
    always_ff @(posedge clk_i) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_sipo_db.sv
// Directed bench for sipo_db: scoreboard of expected frames, immediate-assertion checks.
module tb_sipo_db;

    logic        clk;
    logic        reset_ni;
    logic        valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [7:0]  data_i;
    logic [31:0] data_o;

    logic        v2, r2o, f2, vo2, ri2;
    logic [15:0] d2;
    logic [31:0] do2;

    logic [31:0] sb_q[$];
    logic [31:0] m_buf;
    int          m_ptr;
    int          n_checks;
    int          n_pass;

    sipo_db #(.width_p(8), .depth_p(4), .lanes_p(1)) u_dut (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o)
    );

    sipo_db #(.width_p(8), .depth_p(4), .lanes_p(2)) u_dut_lanes (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(v2), .ready_o(r2o),
        .data_i(d2), .flush_i(f2), .valid_o(vo2), .ready_i(ri2),
        .data_o(do2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called with inputs already applied after a negedge; models the edge, then moves to the next negedge.
    task automatic tick();
        logic ai, ao;
        ai = valid_i & ready_o;
        ao = valid_o & ready_i;
        if (ao) begin
            chk("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("sb_frame", data_o, sb_q.pop_front());
        end
        if (ai) begin
            m_buf[m_ptr*8 +: 8] = data_i;
            m_ptr++;
        end
`ifdef SIPO_DB_FLUSH_EN
        if (flush_i && ready_o && m_ptr != 0 && m_ptr != 4) begin
            for (int e = m_ptr; e < 4; e++) m_buf[e*8 +: 8] = 8'h00;
            m_ptr = 4;
        end
`endif
        if (m_ptr == 4) begin
            sb_q.push_back(m_buf);
            m_ptr = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ptr    = 0;
        m_buf    = '0;
        reset_ni = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        flush_i  = 1'b0;
        ready_i  = 1'b0;
        v2       = 1'b0;
        d2       = '0;
        f2       = 1'b0;
        ri2      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready_lanes", r2o, 0);
        reset_ni = 1'b1;
        #1;
        chk("post_rst_ready", ready_o, 1);

        // Single frame
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'(8'h11 * (i + 1));
            tick();
        end
        valid_i = 1'b0;
        chk("t1_valid", valid_o, 1);
        chk("t1_data", data_o, 32'h44332211);
        tick();
        chk("t1_valid_drop", valid_o, 0);

        // Backpressure: 12 beats offered, consumer stalled
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_i = 8'(i);
            tick();
        end
        chk("t2_ready_after8", ready_o, 0);
        chk("t2_valid_held", valid_o, 1);
        chk("t2_frame1", data_o, 32'h04030201);
        data_i = 8'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall", ready_o, 0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t2_ready_freed", ready_o, 1);
        for (int i = 9; i <= 12; i++) begin
            data_i = 8'(i);
            tick();
        end
        valid_i = 1'b0;
        chk("t2_full_again", ready_o, 0);
        ready_i = 1'b1;
        repeat (3) tick();
        ready_i = 1'b0;
        chk("t2_drained", valid_o, 0);

        // Streaming with a frame-complete/output-accept collision
        valid_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            data_i  = 8'(8'h20 + i);
            ready_i = (i >= 8);
            tick();
            chk("t3_ready", ready_o, 1);
            if (i == 8) begin
                chk("t3_no_bubble", valid_o, 1);
                chk("t3_frame2", data_o, 32'h28272625);
            end
        end
        valid_i = 1'b0;
        repeat (2) tick();
        ready_i = 1'b0;
        chk("t3_drained", valid_o, 0);

        // Two lanes per beat
        v2 = 1'b1;
        d2 = 16'hBBAA;
        @(negedge clk);
        chk("t4_valid_early", vo2, 0);
        d2 = 16'hDDCC;
        @(negedge clk);
        v2 = 1'b0;
        chk("t4_valid", vo2, 1);
        chk("t4_data", do2, 32'hDDCCBBAA);
        ri2 = 1'b1;
        @(negedge clk);
        ri2 = 1'b0;
        chk("t4_drained", vo2, 0);

`ifdef SIPO_DB_FLUSH_EN
        // Flush with zero fill over stale 0xFF banks
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hFF;
        repeat (8) tick();
        valid_i = 1'b0;
        repeat (2) tick();
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h01;
        tick();
        data_i  = 8'h02;
        flush_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("t5_flush_valid", valid_o, 1);
        chk("t5_flush_data", data_o, 32'h00000201);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t5_flush_drained", valid_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t5_empty_flush", valid_o, 0);
        tick();
        chk("t5_empty_flush_later", valid_o, 0);
`else
        // Flush is ignored in the default build
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h01;
        tick();
        data_i  = 8'h02;
        flush_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        tick();
        chk("t5_flush_ignored", valid_o, 0);
        valid_i = 1'b1;
        data_i  = 8'h03;
        tick();
        data_i  = 8'h04;
        tick();
        valid_i = 1'b0;
        chk("t5_full_valid", valid_o, 1);
        chk("t5_full_data", data_o, 32'h04030201);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t5_drained", valid_o, 0);
`endif

        // Mid-frame reset with a held frame discarded
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = 8'(8'h51 + i);
            tick();
        end
        valid_i = 1'b0;
        chk("t6_held_before_rst", valid_o, 1);
        reset_ni = 1'b0;
        #1;
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_ready", ready_o, 0);
        sb_q.delete();
        m_ptr = 0;
        @(negedge clk);
        reset_ni = 1'b1;
        #1;
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'(8'h71 + i);
            tick();
        end
        valid_i = 1'b0;
        chk("t6_fresh_valid", valid_o, 1);
        chk("t6_fresh_data", data_o, 32'h74737271);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t6_one_frame", valid_o, 0);
        tick();
        chk("t6_still_empty", valid_o, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
